// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave memory bus arbiter with per-transaction grant lock and wait timeout.
// Latency: zero added; the winning master is forwarded to the slave in the cycle it requests.
// Backpressure: loser (or a master arriving while locked) waits; slave stalls via s_ready, bounded by TIMEOUT_CYCLES.
//
// Ports:
//   clk, res                      clock, synchronous active-high reset
//   mN_accessType/addr/dataOut    master N request (N = 0,1), held stable until mN_ready
//   mN_dataIn/ready/err           read data (always s_dataIn), completion strobe, timeout flag
//   s_accessType/addr/dataOut     forwarded request to the slave
//   s_dataIn, s_ready             slave read data and completion
//   grant                         one-hot bus owner this cycle, 00 when none
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break;
// otherwise master 0 always wins ties and no last-grant register is built.

`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T logic [1:0]
`endif
`ifndef MEM_ACCESS_NONE
`define MEM_ACCESS_NONE 2'b00
`define MEM_ACCESS_X    2'b01
`define MEM_ACCESS_R    2'b10
`define MEM_ACCESS_W    2'b11
`endif

module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         res,
   input  `MEM_ACCESS_T m0_accessType,
   input  logic [31:0]  m0_addr,
   input  logic [31:0]  m0_dataOut,
   output logic [31:0]  m0_dataIn,
   output logic         m0_ready,
   output logic         m0_err,
   input  `MEM_ACCESS_T m1_accessType,
   input  logic [31:0]  m1_addr,
   input  logic [31:0]  m1_dataOut,
   output logic [31:0]  m1_dataIn,
   output logic         m1_ready,
   output logic         m1_err,
   output `MEM_ACCESS_T s_accessType,
   output logic [31:0]  s_addr,
   output logic [31:0]  s_dataOut,
   input  logic [31:0]  s_dataIn,
   input  logic         s_ready,
   output logic [1:0]   grant
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY0 = 2'd1,
      ST_BUSY1 = 2'd2
   } state_t;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

   state_t       state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [7:0]   cnt_cur;     // wait count as seen in the current cycle
   logic         req0, req1;
   logic         gnt_vld;     // some master owns the bus this cycle
   logic         owner;       // 0 = master 0, 1 = master 1 (valid with gnt_vld)
   logic         withdraw;    // locked master dropped its request
   logic         done;
   logic         tmo;
   logic         tie_win;
   `MEM_ACCESS_T sel_acc;

   assign req0 = (m0_accessType != `MEM_ACCESS_NONE);
   assign req1 = (m1_accessType != `MEM_ACCESS_NONE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Index of the master granted most recently; resets to master 1 so
   // master 0 takes the first tie.
   logic last_q, last_d;
   assign tie_win = ~last_q;
`else
   assign tie_win = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cnt_cur  = cnt_q;
      gnt_vld  = 1'b0;
      owner    = 1'b0;
      withdraw = 1'b0;
      done     = 1'b0;
      tmo      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d   = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // The grant cycle counts as the first wait cycle.
            cnt_cur = 8'd1;
            if (req0 || req1) begin
               gnt_vld = 1'b1;
               owner   = (req0 && req1) ? tie_win : req1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               last_d  = owner;
`endif
            end
         end
         ST_BUSY0: begin
            gnt_vld  = 1'b1;
            owner    = 1'b0;
            withdraw = !req0;
         end
         ST_BUSY1: begin
            gnt_vld  = 1'b1;
            owner    = 1'b1;
            withdraw = !req1;
         end
         default: ;
      endcase

      if (gnt_vld && !withdraw) begin
         done = s_ready;
         // A slave completing in the limit cycle wins over the timeout.
         tmo  = !s_ready && (cnt_cur == TO_LIM);
         if (done || tmo) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end else begin
            state_d = owner ? ST_BUSY1 : ST_BUSY0;
            cnt_d   = cnt_cur + 8'd1;
         end
      end else begin
         state_d = ST_IDLE;
         cnt_d   = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end

   // Outputs are combinational so the slave sees a request with no added
   // latency; reset gates them so an in-flight access is dropped at once.
   assign sel_acc      = owner ? m1_accessType : m0_accessType;
   assign s_accessType = (res || !gnt_vld || withdraw || tmo) ? `MEM_ACCESS_NONE : sel_acc;
   assign s_addr       = owner ? m1_addr : m0_addr;
   assign s_dataOut    = owner ? m1_dataOut : m0_dataOut;
   assign grant        = (res || !gnt_vld) ? 2'b00 : (owner ? 2'b10 : 2'b01);

   assign m0_dataIn = s_dataIn;
   assign m1_dataIn = s_dataIn;
   assign m0_ready  = !res && gnt_vld && !owner && (done || tmo);
   assign m1_ready  = !res && gnt_vld &&  owner && (done || tmo);
   assign m0_err    = !res && gnt_vld && !owner && tmo;
   assign m1_err    = !res && gnt_vld &&  owner && tmo;

endmodule
